pipelined_ripple_adder: RTL and testbench



---
 rtl/rca_pkg.sv | 26 ++
 rtl/adder_slice.sv | 31 +++
 rtl/full_adder.sv | 13 +
 rtl/pipelined_ripple_adder.sv | 110 +++++++++++
 tb/tb_pipelined_ripple_adder.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rca_pkg.sv
// Shared types for the pipelined ripple adder: operation encoding, slice width
// helper and the per-stage payload carried down the pipeline.
package rca_pkg;

  // Widest operand the stage payload can carry; NUMBITS must not exceed it.
  localparam int MAX_BITS = 64;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic                valid;
    logic                carry;   // carry into the next slice to be added
    logic                ovf;     // carry-into-MSB xor carry-out of the slice just added
    logic [MAX_BITS-1:0] res;     // result slices computed so far
    logic [MAX_BITS-1:0] a;       // operand A, slices still to be added
    logic [MAX_BITS-1:0] b;       // operand B' (already inverted for subtract)
  } stage_t;

  function automatic int chunk_width(input int numbits, input int stages);
    return numbits / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple chain of full_adder cells; also exposes the carry
// into its most significant bit for signed-overflow detection.
module adder_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout  = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple chains.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_ripple_adder.sv
// NUMBITS-wide add/subtract split into STAGES registered ripple slices with
// valid/ready on both sides. Define PIPELINED_RIPPLE_ADDER_OVERFLOW_EN for the overflow output.
module pipelined_ripple_adder
  import rca_pkg::*;
#(
  parameter int NUMBITS = 16,
  parameter int STAGES  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMBITS-1:0] A,
  input  logic [NUMBITS-1:0] B,
  input  logic               carryin,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUMBITS-1:0] result,
  output logic               carryout
`ifdef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
  ,
  output logic               overflow
`endif
);

  localparam int CHUNK = chunk_width(NUMBITS, STAGES);

  // Handshake: a beat enters stage 0 on an edge where in_valid && in_ready and leaves
  // the last stage where out_valid && out_ready. Every stage, bubbles included, moves
  // only when advance = !out_valid || out_ready; otherwise all registers hold.
  logic   advance;
  op_e    op;
  stage_t entry;
  stage_t final_stage;

  assign advance  = !final_stage.valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    op                   = sub ? OP_SUB : OP_ADD;
    entry                = '0;
    entry.valid          = in_valid;
    entry.a[NUMBITS-1:0] = A;
    entry.b[NUMBITS-1:0] = (op == OP_SUB) ? ~B : B;
    entry.carry          = (op == OP_SUB) ? 1'b1 : carryin;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           stage_in;
    stage_t           stage_d;
    stage_t           stage_q;
    logic [CHUNK-1:0] sum;
    logic             cout;
    logic             c_msb;

    if (k == 0) begin : g_first
      assign stage_in = entry;
    end else begin : g_next
      assign stage_in = g_stage[k-1].stage_q;
    end

    adder_slice #(.W(CHUNK)) u_slice (
      .a     (stage_in.a[k*CHUNK +: CHUNK]),
      .b     (stage_in.b[k*CHUNK +: CHUNK]),
      .cin   (stage_in.carry),
      .s     (sum),
      .cout  (cout),
      .c_msb (c_msb)
    );

    always_comb begin
      stage_d                        = stage_in;
      stage_d.res[k*CHUNK +: CHUNK]  = sum;
      stage_d.carry                  = cout;
`ifdef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
      stage_d.ovf                    = c_msb ^ cout;
`else
      stage_d.ovf                    = 1'b0;
`endif
    end

`ifndef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
    logic unused_c_msb;
    assign unused_c_msb = c_msb;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= '0;
      end else if (advance) begin
        stage_q <= stage_d;
      end
    end
  end

  assign final_stage = g_stage[STAGES-1].stage_q;

  assign out_valid = final_stage.valid;
  assign result    = final_stage.res[NUMBITS-1:0];
  assign carryout  = final_stage.carry;
`ifdef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
  assign overflow  = final_stage.ovf;
`endif

  // Operand copies and upper payload bits are dead once the last slice is added.
  logic unused_final;
  assign unused_final = ^{final_stage.a, final_stage.b, final_stage.res, final_stage.ovf};

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench for pipelined_ripple_adder: directed latency/carry/subtract/backpressure/reset
// scenarios plus random traffic on 4-, 1- and 16-stage builds against an arithmetic model.
module tb_pipelined_ripple_adder;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         carryin = 1'b0;
  logic         sub = 1'b0;
  logic         out_ready = 1'b1;
  logic [N-1:0] a_in = '0;
  logic [N-1:0] b_in = '0;

  logic         rdy4, ov4, co4, of4;
  logic [N-1:0] res4;
  logic         rdy1, ov1, co1, of1;
  logic [N-1:0] res1;
  logic         rdy16, ov16, co16, of16;
  logic [N-1:0] res16;

  int total = 0;
  int bad   = 0;

  logic [17:0] exp_q0[$];
  logic [17:0] exp_q1[$];
  logic [17:0] exp_q2[$];

  always #5 clk = ~clk;

  pipelined_ripple_adder #(.NUMBITS(N), .STAGES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4), .A(a_in), .B(b_in),
    .carryin(carryin), .sub(sub), .out_valid(ov4), .out_ready(out_ready), .result(res4),
    .carryout(co4)
`ifdef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
    , .overflow(of4)
`endif
  );

  pipelined_ripple_adder #(.NUMBITS(N), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .A(a_in), .B(b_in),
    .carryin(carryin), .sub(sub), .out_valid(ov1), .out_ready(out_ready), .result(res1),
    .carryout(co1)
`ifdef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
    , .overflow(of1)
`endif
  );

  pipelined_ripple_adder #(.NUMBITS(N), .STAGES(N)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16), .A(a_in), .B(b_in),
    .carryin(carryin), .sub(sub), .out_valid(ov16), .out_ready(out_ready), .result(res16),
    .carryout(co16)
`ifdef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
    , .overflow(of16)
`endif
  );

`ifndef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
  assign of4  = 1'b0;
  assign of1  = 1'b0;
  assign of16 = 1'b0;
`endif

  // Reference: plain integer arithmetic. Returns {overflow, carryout, result}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic sb);
    int   ua, ub, sa, sbv, ur, sr;
    logic co, ov;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (sb) begin
      ur = ua - ub;
      sr = sa - sbv;
      co = (ua >= ub);
    end else begin
      ur = ua + ub + int'(ci);
      sr = sa + sbv + int'(ci);
      co = (ur > 65535);
    end
    ov = (sr > 32767) || (sr < -32768);
`ifndef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
    ov = 1'b0;
`endif
    return {ov, co, ur[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sb_one(input int idx, input logic acc, input logic fire, input logic [17:0] got);
    logic [17:0] e;
    int          sz;
    string       tag;
    tag = $sformatf("sb_dut%0d", idx);
    sz  = (idx == 0) ? exp_q0.size() : (idx == 1) ? exp_q1.size() : exp_q2.size();
    if (fire) begin
      if (sz == 0) begin
        check({tag, "_extra"}, 32'd1, 32'd0);
      end else begin
        case (idx)
          0:       e = exp_q0.pop_front();
          1:       e = exp_q1.pop_front();
          default: e = exp_q2.pop_front();
        endcase
        check(tag, {14'd0, got}, {14'd0, e});
      end
    end
    if (acc) begin
      case (idx)
        0:       exp_q0.push_back(model(a_in, b_in, carryin, sub));
        1:       exp_q1.push_back(model(a_in, b_in, carryin, sub));
        default: exp_q2.push_back(model(a_in, b_in, carryin, sub));
      endcase
    end
  endtask

  task automatic scoreboard();
    sb_one(0, in_valid && rdy4,  ov4  && out_ready, {of4,  co4,  res4});
    sb_one(1, in_valid && rdy1,  ov1  && out_ready, {of1,  co1,  res1});
    sb_one(2, in_valid && rdy16, ov16 && out_ready, {of16, co16, res16});
  endtask

  // Drive one cycle's inputs at the falling edge, then observe settled outputs.
  task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic sb, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    a_in      = a;
    b_in      = b;
    carryin   = ci;
    sub       = sb;
    out_ready = ordy;
    #1;
    scoreboard();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end
  endtask

  task automatic wait_out(input string tag);
    int i;
    i = 0;
    do begin
      idle(1);
      i++;
    end while (!ov4 && i < 20);
    if (!ov4) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] bp_a[8];
    logic [15:0] bp_b[8];
    logic [16:0] prev;
    logic        held, iv, ordy;
    int          sent, got, stale, idx;

    // Reset state
    idle(2);
    check("rst_out_valid", {31'd0, ov4}, 32'd0);
    check("rst_in_ready",  {31'd0, rdy4}, 32'd1);
    check("rst_result",    {16'd0, res4}, 32'd0);
    check("rst_carryout",  {31'd0, co4}, 32'd0);
    check("rst_overflow",  {31'd0, of4}, 32'd0);
    check("rst_out_valid_s1",  {31'd0, ov1}, 32'd0);
    check("rst_out_valid_s16", {31'd0, ov16}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Latency: valid exactly three edges after the accepting edge
    step(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
    idle(3);
    check("lat_not_yet", {31'd0, ov4}, 32'd0);
    idle(1);
    check("lat_valid",  {31'd0, ov4}, 32'd1);
    check("lat_result", {16'd0, res4}, 32'h5555);
    check("lat_co",     {31'd0, co4}, 32'd0);

    // Carries crossing slice boundaries, back to back
    step(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    wait_out("xs");
    check("xs1_result", {16'd0, res4}, 32'h0100);
    check("xs1_co",     {31'd0, co4}, 32'd0);
    idle(1);
    check("xs2_valid",  {31'd0, ov4}, 32'd1);
    check("xs2_result", {16'd0, res4}, 32'h0000);
    check("xs2_co",     {31'd0, co4}, 32'd1);

    // Subtract, borrow semantics and signed overflow
    step(1'b1, 16'd5, 16'd7, 1'b1, 1'b1, 1'b1);
    step(1'b1, 16'd7, 16'd5, 1'b0, 1'b1, 1'b1);
    step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    wait_out("sub");
    check("sub1_result", {16'd0, res4}, 32'hFFFE);
    check("sub1_co",     {31'd0, co4}, 32'd0);
    idle(1);
    check("sub2_result", {16'd0, res4}, 32'h0002);
    check("sub2_co",     {31'd0, co4}, 32'd1);
    idle(1);
    check("ovf_result",  {16'd0, res4}, 32'h8000);
`ifdef PIPELINED_RIPPLE_ADDER_OVERFLOW_EN
    check("ovf_flag",    {31'd0, of4}, 32'd1);
`endif

    // Backpressure: 8 beats with out_ready low for 5 cycles mid-stream
    for (int i = 0; i < 8; i++) begin
      bp_a[i] = 16'($urandom);
      bp_b[i] = 16'($urandom);
    end
    sent = 0;
    got  = 0;
    held = 1'b0;
    prev = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      ordy = !(cyc >= 4 && cyc < 9);
      iv   = (sent < 8);
      idx  = (sent < 8) ? sent : 0;
      step(iv, bp_a[idx], bp_b[idx], 1'b0, 1'(idx), ordy);
      if (held) check("bp_hold", {15'd0, co4, res4}, {15'd0, prev});
      if (ov4 && !ordy) check("bp_in_ready", {31'd0, rdy4}, 32'd0);
      held = ov4 && !ordy;
      prev = {co4, res4};
      if (iv && rdy4) sent++;
      if (ov4 && ordy) got++;
    end
    check("bp_sent", sent, 32'd8);
    check("bp_got",  got, 32'd8);

    // Reset with beats in flight
    idle(1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_valid",     {31'd0, ov4}, 32'd0);
    check("mid_rst_result",    {16'd0, res4}, 32'd0);
    check("mid_rst_valid_s1",  {31'd0, ov1}, 32'd0);
    check("mid_rst_result_s1", {16'd0, res1}, 32'd0);
    check("mid_rst_valid_s16", {31'd0, ov16}, 32'd0);
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    idle(2);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (ov4 || ov1 || ov16) stale++;
    end
    check("post_rst_stale", stale, 32'd0);

    // Random traffic on all three builds
    for (int cyc = 0; cyc < 2500; cyc++) begin
      step(($urandom_range(0, 9) < 8), pick(), pick(), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0));
    end
    idle(40);
    check("drain_dut0", exp_q0.size(), 32'd0);
    check("drain_dut1", exp_q1.size(), 32'd0);
    check("drain_dut2", exp_q2.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
